// File: rtl/ucode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: trap opcodes, routine entry
// points, ROM word layout, FSM encoding and the substituted register fields.
package ucode_sequencer_pkg;

  localparam logic [6:0] OP_MUL0 = 7'b0010000;
  localparam logic [6:0] OP_MUL1 = 7'b0011000;
  localparam logic [6:0] OP_MUL2 = 7'b0110000;
  localparam logic [6:0] OP_MUL3 = 7'b0111000;

  localparam logic [4:0] ENTRY_MUL0 = 5'h00;
  localparam logic [4:0] ENTRY_MUL1 = 5'h08;
  localparam logic [4:0] ENTRY_MUL2 = 5'h10;
  localparam logic [4:0] ENTRY_MUL3 = 5'h18;

  localparam int RD_LSB = 21;
  localparam int RD_MSB = 24;
  localparam int RS_LSB = 17;
  localparam int RS_MSB = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRO  = 3'd1;
  localparam logic [2:0] ST_BODY = 3'd2;
  localparam logic [2:0] ST_EPI  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Field order gives bit 35 = last, 34 = reserved, 33 = subst_rs, 32 = subst_rd.
  typedef struct packed {
    logic        last;
    logic        rsvd;
    logic        subst_rs;
    logic        subst_rd;
    logic [31:0] inst;
  } rom_word_t;

  function automatic logic is_trappable(input logic [6:0] op);
    return (op == OP_MUL0) || (op == OP_MUL1) || (op == OP_MUL2) || (op == OP_MUL3);
  endfunction

  function automatic logic [4:0] entry_of(input logic [6:0] op);
    logic [4:0] e;
    case (op)
      OP_MUL1: e = ENTRY_MUL1;
      OP_MUL2: e = ENTRY_MUL2;
      OP_MUL3: e = ENTRY_MUL3;
      default: e = ENTRY_MUL0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] apply_subst(input rom_word_t w, input logic [3:0] rd,
                                              input logic [3:0] rs);
    logic [31:0] r;
    r = w.inst;
    if (w.subst_rd) r[RD_MSB:RD_LSB] = rd;
    if (w.subst_rs) r[RS_MSB:RS_LSB] = rs;
    return r;
  endfunction

endpackage

// File: rtl/ucode_sequencer_rom.sv
// Microcode store: 32 words of 36 bits, combinational read.
// Each routine is prologue, loop body, then epilogue up to the first last=1 word.
module ucode_rom
  import ucode_sequencer_pkg::*;
(
  input  logic [4:0] addr_i,
  output rom_word_t  word_o
);

  always_comb begin
    case (addr_i)
      5'h00: word_o = 36'h3_0200_0013;
      5'h01: word_o = 36'h3_0200_8033;
      5'h02: word_o = 36'h1_0010_0013;
      5'h03: word_o = 36'h8_0000_0073;
      5'h08: word_o = 36'h2_0040_0013;
      5'h09: word_o = 36'h3_1234_5033;
      5'h0A: word_o = 36'h9_0ABC_D013;
      5'h10: word_o = 36'h3_0FF0_0013;
      5'h11: word_o = 36'h3_4000_0033;
      5'h12: word_o = 36'h2_0000_1013;
      5'h13: word_o = 36'h0_DEAD_0013;
      5'h14: word_o = 36'hB_0000_BEEF;
      5'h18: word_o = 36'h1_5550_0013;
      5'h19: word_o = 36'h3_AA00_0033;
      5'h1A: word_o = 36'h0_00C0_FFEE;
      5'h1B: word_o = 36'h8_0000_0067;
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Expands a trapped multiply into a microcode routine issued to decode as
// ghost instructions, freezing fetch until the routine completes.
//
// state | meaning
// IDLE  | waiting for a trap; trap_ready high
// PRO   | prologue word issued
// BODY  | loop body word issued, reissued cnt times
// EPI   | epilogue words issued until last=1
// DONE  | ucode_done pulse, back to IDLE
module ucode_sequencer
  import ucode_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [6:0]  trap_opcode,
  input  logic [3:0]  trap_rd,
  input  logic [3:0]  trap_rs,
  input  logic [15:0] trap_imm,
  output logic        trap_ready,
  output logic        ghost_valid,
  output logic [31:0] ghost_inst,
  input  logic        ghost_ready,
  output logic        ucode_active,
  output logic        ucode_done,
  output logic        bad_trap
);

  logic [2:0]  state_q, state_d;
  logic [4:0]  gpc_q, gpc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rs_q, rs_d;
  logic [31:0] ginst_q, ginst_d;
  logic        gvalid_q, gvalid_d;
  logic        last_q, last_d;
  logic        bad_q, bad_d;
  logic        load;
  logic        accept;
  rom_word_t   rom_w;

  // ROM looks at the next gPC so the ghost register is filled on the same edge gPC moves.
  ucode_rom u_rom (
    .addr_i (gpc_d),
    .word_o (rom_w)
  );

  assign accept = gvalid_q & ghost_ready;

  always_comb begin
    state_d  = state_q;
    gpc_d    = gpc_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    gvalid_d = gvalid_q;
    bad_d    = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trap_valid) begin
          if (is_trappable(trap_opcode)) begin
            state_d  = ST_PRO;
            gpc_d    = entry_of(trap_opcode);
            cnt_d    = trap_imm;
            rd_d     = trap_rd;
            rs_d     = trap_rs;
            gvalid_d = 1'b1;
            load     = 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      ST_PRO: begin
        if (accept) begin
          load = 1'b1;
          if (cnt_q == 16'd0) begin
            gpc_d   = gpc_q + 5'd2;
            state_d = ST_EPI;
          end else begin
            gpc_d   = gpc_q + 5'd1;
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        // Exit on cnt==1 rather than counting to zero, so cnt never wraps.
        if (accept) begin
          load = 1'b1;
          if (cnt_q == 16'd1) begin
            gpc_d   = gpc_q + 5'd1;
            state_d = ST_EPI;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      ST_EPI: begin
        if (accept) begin
          if (last_q) begin
            state_d  = ST_DONE;
            gvalid_d = 1'b0;
          end else begin
            gpc_d = gpc_q + 5'd1;
            load  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ginst_d = load ? apply_subst(rom_w, rd_d, rs_d) : ginst_q;
    last_d  = load ? rom_w.last : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gpc_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      ginst_q  <= '0;
      gvalid_q <= 1'b0;
      last_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gpc_q    <= gpc_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      ginst_q  <= ginst_d;
      gvalid_q <= gvalid_d;
      last_q   <= last_d;
      bad_q    <= bad_d;
    end
  end

  assign trap_ready   = (state_q == ST_IDLE);
  assign ucode_active = (state_q != ST_IDLE);
  assign ucode_done   = (state_q == ST_DONE);
  assign ghost_valid  = gvalid_q;
  assign ghost_inst   = ginst_q;
  assign bad_trap     = bad_q;

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 trap_valid  input  1  fetch presents a trapped multiply.
REQ-004 trap_opcode  input  7  opcode of the trapped instruction.
REQ-005 trap_rd  input  4  destination register field.
REQ-006 trap_rs  input  4  source register field.
REQ-007 trap_imm  input  16  immediate; unsigned iteration count N.
REQ-008 trap_ready  output  1  sequencer accepts a trap this cycle.
REQ-009 ghost_valid  output  1  ghost_inst is valid.
REQ-010 ghost_inst  output  32  microcode instruction to decode.
REQ-011 ghost_ready  input  1  decode accepts ghost_inst.
REQ-012 ucode_active  output  1  fetch freezes its PC while high.
REQ-013 ucode_done  output  1  one-cycle pulse at sequence completion.
REQ-014 bad_trap  output  1  one-cycle pulse for an unrecognised trap opcode.

Function
REQ-015 Trappable opcodes are 7'b0010000, 7'b0011000, 7'b0110000 and 7'b0111000, with ROM entry word addresses 0x00, 0x08, 0x10 and 0x18 respectively (5-bit ghost PC, gPC).
REQ-016 ROM word is 36 bits: [31:0] template instruction, [32] subst_rd, [33] subst_rs, [34] reserved (0), [35] last.
REQ-017 Every routine has a fixed layout: entry+0 prologue, entry+1 loop body, entry+2 onward epilogue, ending at the first word with last=1.
REQ-018 The state machine has states IDLE, PRO, BODY, EPI and DONE.
REQ-019 trap_ready = 1 only in IDLE.
REQ-020 IDLE with trap_valid and a trappable opcode: latch rd/rs, load cnt=trap_imm, set gPC=entry, move to PRO.
REQ-021 IDLE with trap_valid and a non-trappable opcode: pulse bad_trap the next cycle and remain in IDLE.
REQ-022 ghost_inst and ghost_valid are registered and are loaded on the cycle of each state or gPC change, so ghost_valid rises exactly 1 cycle after trap acceptance.
REQ-023 When subst_rd=1, ghost_inst[24:21] is replaced by the latched rd.
REQ-024 When subst_rs=1, ghost_inst[20:17] is replaced by the latched rs.
REQ-025 Advancement occurs only on a cycle with ghost_valid and ghost_ready both high.
REQ-026 While ghost_ready is low, ghost_inst is held stable.
REQ-027 PRO accept: if cnt==0, gPC=entry+2 and move to EPI; otherwise gPC=entry+1 and move to BODY.
REQ-028 BODY accept: if cnt==1, gPC=entry+2 and move to EPI; otherwise decrement cnt and reissue the same word.
REQ-029 EPI accept of a word with last=1: move to DONE and drop ghost_valid; otherwise gPC+1.
REQ-030 DONE: pulse ucode_done for 1 cycle, then return to IDLE.
REQ-031 ucode_active = 1 in PRO, BODY, EPI and DONE.
REQ-032 Per trap, the total number of issued instructions is 1 + N + (epilogue length).
REQ-033 N=16'hFFFF requires no special casing; cnt never wraps.

Reset
REQ-034 While rst is high, the FSM goes to IDLE and gPC=0, cnt=0, ghost_inst=0.
REQ-035 While rst is high, ghost_valid, ucode_active, ucode_done and bad_trap are all 0.
REQ-036 rst asserted mid-sequence aborts the sequence: no ucode_done pulse, and trap_ready=1 the cycle after rst deasserts.

Structure
REQ-037 A shared package holds the trappable opcode constants, entry addresses, ROM word bit positions, state encoding and the rd/rs field positions.
REQ-038 Sub-module ucode_rom: 32x36 ROM, asynchronous read, addressed by gPC; unused words are 0.

Verification
REQ-039 trap opcode 0010000, rd=3, rs=5, imm=3, ghost_ready tied 1 -> prologue, body x3, epilogue; every rd field is 3 and every rs field is 5; one ucode_done pulse.
REQ-040 imm=0 -> prologue then epilogue directly, no body words issued.
REQ-041 imm=2 with ghost_ready low for 4 cycles mid-body -> ghost_inst stable during the stall, body issued exactly 2 times.
REQ-042 trap_opcode 7'b1000000 -> bad_trap pulses once, trap_ready stays 1, ucode_active stays 0.
REQ-043 rst asserted during BODY with imm=10 -> all outputs 0 next cycle, no ucode_done, and a new trap is accepted after rst deasserts.
REQ-044 trap_valid held high during an active sequence -> no acceptance until the cycle after ucode_done; back-to-back traps run their sequences correctly.
